pulse_output_register_bank: RTL

Multi-channel successor to the single output register: a bank of `CHANNELS` independent output registers on the peripheral bus, each supporting write/set/clear/toggle with byte-lane masking. Each channel also has an optional auto-clearing pulse mode: bits raised by a SET operation are cleared by hardware after a programmable number of cycles. The block sits in a peripheral's register file and drives GPIO-style outputs, strobes and enables.

---
 rtl/pulse_output_register_bank.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pulse_output_register_bank.sv
// Bank of CHANNELS bus-writable output registers with write/set/clear/toggle and optional auto-clearing pulses.
// Pulse timers, masks and the control space are built only when PULSE_OUTPUT_REGISTER_BANK_PULSE_EN is defined.
module pulse_output_register_bank #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned CHANNELS    = 4,
    parameter logic [3:0]  ADDRESS     = 4'h0,
    parameter logic [31:0] DEFAULT     = 32'h0,
    parameter int unsigned PULSE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      peripheralBus_we,
    input  logic                      peripheralBus_oe,
    input  logic [11:0]               peripheralBus_address,
    input  logic [3:0]                peripheralBus_byteSelect,
    input  logic [31:0]               peripheralBus_dataWrite,
    output logic [31:0]               peripheralBus_dataRead,
    output logic                      requestOutput,
    output logic [CHANNELS*WIDTH-1:0] currentValue,
    output logic [CHANNELS-1:0]       pulseActive
);

    logic [2:0]       ch_s;
    logic [1:0]       op_s;
    logic             ctrl_s;
    logic             aligned_s;
    logic             sel_s;
    logic             wr_s;
    logic             rd_s;
    logic [31:0]      lane_mask_s;
    logic [31:0]      wdata_s;
    logic [WIDTH-1:0] m_s;
    logic [WIDTH-1:0] d_s;
    logic [WIDTH-1:0] cur_s;

    logic [WIDTH-1:0] val_q [CHANNELS];
    logic [WIDTH-1:0] val_d [CHANNELS];

`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
    logic [PULSE_WIDTH-1:0] plen_q  [CHANNELS];
    logic [PULSE_WIDTH-1:0] plen_d  [CHANNELS];
    logic [PULSE_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [PULSE_WIDTH-1:0] cnt_d   [CHANNELS];
    logic [WIDTH-1:0]       pmask_q [CHANNELS];
    logic [WIDTH-1:0]       pmask_d [CHANNELS];
    logic [CHANNELS-1:0]    active_q;
    logic [CHANNELS-1:0]    active_d;
    logic [PULSE_WIDTH-1:0] plen_sel_s;
    logic [WIDTH-1:0]       pmask_sel_s;
    logic                   active_sel_s;
`endif

    assign ch_s        = peripheralBus_address[6:4];
    assign op_s        = peripheralBus_address[3:2];
    assign ctrl_s      = peripheralBus_address[7];
    assign aligned_s   = (peripheralBus_address[1:0] == 2'b00);
    assign sel_s       = enable && (peripheralBus_address[11:8] == ADDRESS) && (32'(ch_s) < CHANNELS);
    assign wr_s        = sel_s && peripheralBus_we && !peripheralBus_oe && aligned_s;
    assign rd_s        = sel_s && peripheralBus_oe && !peripheralBus_we;
    assign lane_mask_s = {{8{peripheralBus_byteSelect[3]}}, {8{peripheralBus_byteSelect[2]}},
                          {8{peripheralBus_byteSelect[1]}}, {8{peripheralBus_byteSelect[0]}}};
    assign wdata_s     = peripheralBus_dataWrite & lane_mask_s;
    assign m_s         = lane_mask_s[WIDTH-1:0];
    assign d_s         = wdata_s[WIDTH-1:0];

    // Next-state: pulse expiry is resolved first so a bus op in the same cycle sees the cleared value.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            val_d[n] = val_q[n];
`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
            plen_d[n]  = plen_q[n];
            cnt_d[n]   = cnt_q[n];
            pmask_d[n] = pmask_q[n];
            if (cnt_q[n] == PULSE_WIDTH'(1)) begin
                val_d[n]   = val_q[n] & ~pmask_q[n];
                pmask_d[n] = '0;
                cnt_d[n]   = '0;
            end else if (cnt_q[n] != '0) begin
                cnt_d[n] = cnt_q[n] - PULSE_WIDTH'(1);
            end else begin
                cnt_d[n] = '0;
            end
            if (wr_s && ctrl_s && (op_s == 2'b00) && (ch_s == 3'(n))) begin
                plen_d[n] = wdata_s[PULSE_WIDTH-1:0] | (plen_q[n] & ~lane_mask_s[PULSE_WIDTH-1:0]);
            end else begin
                plen_d[n] = plen_q[n];
            end
`endif
            if (wr_s && !ctrl_s && (ch_s == 3'(n))) begin
                case (op_s)
                    2'b00: val_d[n] = d_s | (val_d[n] & ~m_s);
                    2'b01: begin
                        val_d[n] = val_d[n] | d_s;
`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
                        if (plen_q[n] != '0) begin
                            cnt_d[n]   = plen_q[n];
                            pmask_d[n] = pmask_d[n] | d_s;
                        end else begin
                            pmask_d[n] = pmask_d[n];
                        end
`endif
                    end
                    2'b10:   val_d[n] = val_d[n] & ~d_s;
                    2'b11:   val_d[n] = val_d[n] ^ d_s;
                    default: val_d[n] = val_d[n];
                endcase
            end else begin
                val_d[n] = val_d[n];
            end
        end
    end

`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
    // Pulse flag tracks whether the counter will be running after this edge.
    always_comb begin
        active_d = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            active_d[n] = (cnt_d[n] != '0);
        end
    end
`endif

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < CHANNELS; n++) begin
                val_q[n] <= DEFAULT[WIDTH-1:0];
`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
                plen_q[n]  <= '0;
                cnt_q[n]   <= '0;
                pmask_q[n] <= '0;
`endif
            end
`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
            active_q <= '0;
`endif
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                val_q[n] <= val_d[n];
`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
                plen_q[n]  <= plen_d[n];
                cnt_q[n]   <= cnt_d[n];
                pmask_q[n] <= pmask_d[n];
`endif
            end
`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
            active_q <= active_d;
`endif
        end
    end

    // Combinational read mux; out-of-range channels never reach here because rd_s is low.
    always_comb begin
        cur_s = '0;
`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
        plen_sel_s   = '0;
        pmask_sel_s  = '0;
        active_sel_s = 1'b0;
`endif
        for (int n = 0; n < CHANNELS; n++) begin
            cur_s = (ch_s == 3'(n)) ? val_q[n] : cur_s;
`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
            plen_sel_s   = (ch_s == 3'(n)) ? plen_q[n]   : plen_sel_s;
            pmask_sel_s  = (ch_s == 3'(n)) ? pmask_q[n]  : pmask_sel_s;
            active_sel_s = (ch_s == 3'(n)) ? active_q[n] : active_sel_s;
`endif
        end
        peripheralBus_dataRead = 32'h0;
        if (rd_s && aligned_s && !ctrl_s) begin
            peripheralBus_dataRead = 32'(cur_s) & lane_mask_s;
        end else if (rd_s && aligned_s) begin
`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
            case (op_s)
                2'b00:   peripheralBus_dataRead = 32'(plen_sel_s);
                2'b01:   peripheralBus_dataRead = {31'h0, active_sel_s};
                2'b10:   peripheralBus_dataRead = 32'(pmask_sel_s);
                default: peripheralBus_dataRead = 32'h0;
            endcase
`else
            peripheralBus_dataRead = 32'h0;
`endif
        end else begin
            peripheralBus_dataRead = 32'h0;
        end
    end

    assign requestOutput = rd_s;

    // Flatten the channel registers onto the output bus.
    always_comb begin
        currentValue = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            currentValue[n*WIDTH +: WIDTH] = val_q[n];
        end
    end

`ifdef PULSE_OUTPUT_REGISTER_BANK_PULSE_EN
    assign pulseActive = active_q;
`else
    assign pulseActive = '0;
`endif

endmodule
